// File: rtl/eight_bit_ripple_pkg.sv
// Shared constants for the ripple-carry adder/subtractor slice.
// Default operand width and the op-select encoding.
package eight_bit_ripple_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/eight_bit_ripple_full_adder.sv
// Single-bit full adder; one stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/eight_bit_ripple.sv
// Two's-complement ripple-carry adder/subtractor with registered sum and
// signed-overflow flag; one-cycle latency, new operation every cycle.
module eight_bit_ripple
  import eight_bit_ripple_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH:0]   c;
  logic             overflow_next;

  // Subtract is a + ~b + 1: invert b and inject the +1 as carry-in.
  always_comb begin
    sub   = (op == OP_SUB);
    b_eff = b ^ {WIDTH{sub}};
  end

  assign c[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (c[i]),
      .s    (sum_next[i]),
      .cout (c[i+1])
    );
  end

  // Carry into MSB differs from carry out of MSB only on signed overflow.
  always_comb begin
    overflow_next = c[WIDTH] ^ c[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      sum      <= sum_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_eight_bit_ripple.sv
// Self-checking bench for eight_bit_ripple: directed corner cases, reset
// behaviour, and randomized alternating add/subtract against an integer model.
module tb_eight_bit_ripple;
  import eight_bit_ripple_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       op;
  logic [7:0] sum;
  logic       overflow;

  int total;
  int bad;

  eight_bit_ripple #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .op       (op),
    .sum      (sum),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed integer result, then wrap to 8 bits.
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                input logic mop, output logic [7:0] s,
                                output logic o);
    int r;
    int sa;
    int sb;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = (mop == OP_SUB) ? (sa - sb) : (sa + sb);
    s  = r[7:0];
    o  = (r > 127) || (r < -128);
  endfunction

  task automatic chk(input string tag, input logic [7:0] s_exp, input logic o_exp);
    total++;
    assert (sum === s_exp)
    else begin
      bad++;
      $error("FAIL %s sum got=%h exp=%h", tag, sum, s_exp);
    end
    total++;
    assert (overflow === o_exp)
    else begin
      bad++;
      $error("FAIL %s overflow got=%b exp=%b", tag, overflow, o_exp);
    end
  endtask

  // Apply operands, capture on the next rising edge, check 1 ns later.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic top);
    logic [7:0] es;
    logic       eo;
    a  = ta;
    b  = tb;
    op = top;
    model(ta, tb, top, es, eo);
    @(posedge clk);
    #1;
    chk(tag, es, eo);
  endtask

  task automatic run_fixed(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                           input logic top, input logic [7:0] es, input logic eo);
    a  = ta;
    b  = tb;
    op = top;
    @(posedge clk);
    #1;
    chk(tag, es, eo);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    op    = OP_ADD;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_init", 8'h00, 1'b0);
    rst_n = 1'b1;

    run_fixed("add_5_3",     8'h05, 8'h03, OP_ADD, 8'h08, 1'b0);
    run_fixed("add_ff_01",   8'hFF, 8'h01, OP_ADD, 8'h00, 1'b0);
    run_fixed("add_7f_01",   8'h7F, 8'h01, OP_ADD, 8'h80, 1'b1);
    run_fixed("add_80_80",   8'h80, 8'h80, OP_ADD, 8'h00, 1'b1);
    run_fixed("sub_5_3",     8'h05, 8'h03, OP_SUB, 8'h02, 1'b0);
    run_fixed("sub_3_5",     8'h03, 8'h05, OP_SUB, 8'hFE, 1'b0);
    run_fixed("sub_80_01",   8'h80, 8'h01, OP_SUB, 8'h7F, 1'b1);
    run_fixed("sub_00_80",   8'h00, 8'h80, OP_SUB, 8'h80, 1'b1);
    run_fixed("sub_a_a",     8'h5A, 8'h5A, OP_SUB, 8'h00, 1'b0);
    run_fixed("sub_80_80",   8'h80, 8'h80, OP_SUB, 8'h00, 1'b0);

    // Load a nonzero result with overflow set, then reset mid-cycle.
    run_fixed("pre_reset",   8'h7F, 8'h7F, OP_ADD, 8'hFE, 1'b1);
    #3;
    a     = 8'h12;
    b     = 8'h34;
    op    = OP_ADD;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_hold", 8'h00, 1'b0);
    rst_n = 1'b1;
    #2;
    chk("reset_release", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("post_reset", 8'h46, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op("random", 8'($urandom), 8'($urandom), (i % 2 == 1) ? OP_SUB : OP_ADD);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
